wca_synch_pulse_gen: RTL and testbench



---
 rtl/wca_pulse_pkg.sv | 23 ++
 rtl/wca_phase_timer.sv | 40 ++++
 rtl/wca_synch_pulse_gen.sv | 156 +++++++++++++++
 tb/tb_wca_synch_pulse_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/wca_pulse_pkg.sv
// Shared state encoding and length helper for the synchronizing pulse generator.
package wca_pulse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } pulse_state_e;

    localparam int LEN_MAX_WIDTH = 32;

    // A programmed length of 0 behaves exactly like a length of 1.
    function automatic logic [LEN_MAX_WIDTH-1:0] clamp_len(input logic [LEN_MAX_WIDTH-1:0] len);
        logic [LEN_MAX_WIDTH-1:0] res;
        if (len == 32'd0) begin
            res = 32'd1;
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/wca_phase_timer.sv
// Loadable down-counter timing one HIGH or LOW phase; zero_o marks the final cycle.
module wca_phase_timer #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load_i,
    input  logic [CNT_WIDTH-1:0] load_val_i,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 zero_o
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Next count: load wins, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/wca_synch_pulse_gen.sv
// Stretches event strobes into pulses with programmable high time and low gap.
// Define WCA_PULSE_QUEUE_EN to queue triggers that arrive while a pulse is in progress.
module wca_synch_pulse_gen
    import wca_pulse_pkg::*;
#(
    parameter int CNT_WIDTH  = 8,
    parameter int PEND_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  trig,
    input  logic [CNT_WIDTH-1:0]  high_len,
    input  logic [CNT_WIDTH-1:0]  low_len,
    input  logic                  clr_ovf,
    output logic                  out,
    output logic                  busy,
    output logic                  done,
    output logic [PEND_WIDTH-1:0] pending,
    output logic                  overflow
);

    pulse_state_e         state_q, state_d;
    logic [CNT_WIDTH-1:0] low_m1_q, low_m1_d;
    logic                 out_q, busy_q, done_q, ovf_q;
    logic                 done_d, ovf_d;
    logic                 tmr_load_s, tmr_zero_s;
    logic [CNT_WIDTH-1:0] tmr_val_s, tmr_cnt_s;
    logic [CNT_WIDTH-1:0] high_m1_s, low_in_m1_s;
    logic                 ready_s, start_s, loss_s;

    assign high_m1_s   = CNT_WIDTH'(clamp_len(LEN_MAX_WIDTH'(high_len)) - 32'd1);
    assign low_in_m1_s = CNT_WIDTH'(clamp_len(LEN_MAX_WIDTH'(low_len)) - 32'd1);
    assign ready_s     = (state_q == ST_IDLE) || ((state_q == ST_LOW) && tmr_zero_s);

`ifdef WCA_PULSE_QUEUE_EN
    logic [PEND_WIDTH-1:0] pend_q, pend_d;
    logic                  pend_nz_s, deq_s, enq_s, full_s;

    // Queued events are served first; a trig that does not start directly is enqueued.
    assign pend_nz_s = (pend_q != '0);
    assign full_s    = (pend_q == '1);
    assign deq_s     = ready_s && pend_nz_s;
    assign start_s   = ready_s && (trig || pend_nz_s);
    assign enq_s     = trig && !(ready_s && !pend_nz_s);
    assign loss_s    = enq_s && !deq_s && full_s;

    // Pending count: saturating, simultaneous enqueue and dequeue cancel.
    always_comb begin
        pend_d = pend_q;
        if (enq_s && !deq_s && !full_s) begin
            pend_d = pend_q + PEND_WIDTH'(1);
        end else if (deq_s && !enq_s) begin
            pend_d = pend_q - PEND_WIDTH'(1);
        end else begin
            pend_d = pend_q;
        end
    end

    // Pending count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pending = pend_q;
`else
    assign start_s = ready_s && trig;
    assign loss_s  = trig && !ready_s;
    assign pending = '0;
`endif

    wca_phase_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_val_s),
        .count_o    (tmr_cnt_s),
        .zero_o     (tmr_zero_s)
    );

    // Phase sequencing; done is precomputed so it lands on the final LOW cycle.
    always_comb begin
        state_d    = state_q;
        low_m1_d   = low_m1_q;
        tmr_load_s = 1'b0;
        tmr_val_s  = '0;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE, ST_LOW: begin
                if (ready_s && start_s) begin
                    state_d    = ST_HIGH;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = high_m1_s;
                    low_m1_d   = low_in_m1_s;
                end else if (ready_s) begin
                    state_d = ST_IDLE;
                end else begin
                    done_d = (tmr_cnt_s == CNT_WIDTH'(1));
                end
            end
            ST_HIGH: begin
                if (tmr_zero_s) begin
                    state_d    = ST_LOW;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = low_m1_q;
                    done_d     = (low_m1_q == '0);
                end else begin
                    state_d = ST_HIGH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A loss in the same cycle as a clear keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (loss_s) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            low_m1_q <= '0;
            out_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            low_m1_q <= low_m1_d;
            out_q    <= (state_d == ST_HIGH);
            busy_q   <= (state_d != ST_IDLE);
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out      = out_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_wca_synch_pulse_gen.sv
// Self-checking bench: directed scenarios plus random traffic against a timeline model.
module tb_wca_synch_pulse_gen;

    localparam int CW   = 8;
    localparam int PW   = 3;
    localparam int QMAX = (1 << PW) - 1;
`ifdef WCA_PULSE_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n, trig, clr_ovf;
    logic [CW-1:0] high_len, low_len;
    logic          out, busy, done, overflow;
    logic [PW-1:0] pending;

    wca_synch_pulse_gen #(.CNT_WIDTH(CW), .PEND_WIDTH(PW)) dut (
        .clk(clk), .reset_n(reset_n), .trig(trig), .high_len(high_len),
        .low_len(low_len), .clr_ovf(clr_ovf), .out(out), .busy(busy),
        .done(done), .pending(pending), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: the most recent pulse was accepted in cycle m_s with lengths m_h/m_l.
    bit m_have;
    int m_s, m_h, m_l, m_q, m_peak;
    bit m_ovf;
    bit e_out, e_busy, e_done;
    int obs_peak, rises;
    bit out_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_have = 1'b0; m_q = 0; m_ovf = 1'b0;
        e_out = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    endtask

    // Advance the model across the edge that ends cycle cyc.
    task automatic model_edge(input bit t, input bit c);
        bit rdy, st, lost;
        int n;
        rdy = !m_have || (cyc >= m_s + m_h + m_l);
        st = 1'b0; lost = 1'b0;
        if (QEN && rdy && m_q > 0) begin
            st = 1'b1;
            m_q = m_q - 1;
            if (t) m_q = m_q + 1;
        end else if (rdy && t) begin
            st = 1'b1;
        end else if (t) begin
            if (QEN && m_q < QMAX) m_q = m_q + 1;
            else lost = 1'b1;
        end
        if (st) begin
            m_have = 1'b1; m_s = cyc;
            m_h = (high_len == 0) ? 1 : int'(high_len);
            m_l = (low_len == 0) ? 1 : int'(low_len);
        end
        if (lost) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        if (m_q > m_peak) m_peak = m_q;
        n = cyc + 1;
        e_out  = m_have && (n >= m_s + 1) && (n <= m_s + m_h);
        e_busy = m_have && (n >= m_s + 1) && (n <= m_s + m_h + m_l);
        e_done = m_have && (n == m_s + m_h + m_l);
    endtask

    task automatic check_all();
        chk("out", 32'(out), 32'(e_out));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("pending", 32'(pending), 32'(m_q));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (int'(pending) > obs_peak) obs_peak = int'(pending);
        if (out && !out_prev) rises++;
        out_prev = out;
    endtask

    task automatic step(input bit t, input bit c);
        trig = t; clr_ovf = c;
        model_edge(t, c);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        reset_n = 1'b1; trig = 1'b0; clr_ovf = 1'b0;
        high_len = 8'd3; low_len = 8'd2;
        model_reset();
        #3 reset_n = 1'b0;
        #1;
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        idle(3);

        // Single pulse H=3 L=2: high for 3 cycles, done 5 after trig, idle at 6.
        step(1'b1, 1'b0);
        chk("sp_out_first", 32'(out), 32'd1);
        idle(2);
        chk("sp_out_last", 32'(out), 32'd1);
        idle(1);
        chk("sp_out_low", 32'(out), 32'd0);
        idle(1);
        chk("sp_done", 32'(done), 32'd1);
        idle(1);
        chk("sp_busy_off", 32'(busy), 32'd0);
        idle(2);

        // Zero lengths behave as one cycle each.
        high_len = 8'd0; low_len = 8'd0;
        step(1'b1, 1'b0);
        chk("zl_out", 32'(out), 32'd1);
        chk("zl_done0", 32'(done), 32'd0);
        idle(1);
        chk("zl_done", 32'(done), 32'd1);
        chk("zl_out_low", 32'(out), 32'd0);
        idle(2);

        // Burst of five consecutive triggers, H=2 L=2.
        high_len = 8'd2; low_len = 8'd2;
        m_peak = 0; obs_peak = 0; rises = 0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        idle(24);
        chk("burst_pulses", 32'(rises), QEN ? 32'd5 : 32'd2);
        chk("burst_peak", 32'(obs_peak), 32'(m_peak));
        chk("burst_ovf", 32'(overflow), QEN ? 32'd0 : 32'd1);
        step(1'b0, 1'b1);

        // Saturation: many triggers during one long pulse, then clear and drain.
        high_len = 8'd30; low_len = 8'd1;
        step(1'b1, 1'b0);
        high_len = 8'd1;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        chk("sat_ovf", 32'(overflow), 32'd1);
        chk("sat_pending", 32'(pending), QEN ? 32'(QMAX) : 32'd0);
        step(1'b0, 1'b1);
        chk("sat_clr", 32'(overflow), 32'd0);
        rises = 0;
        idle(40);
        chk("sat_drain", 32'(rises), QEN ? 32'(QMAX) : 32'd0);

        // Reset during HIGH with events queued.
        high_len = 8'd10; low_len = 8'd2;
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
        chk("mr_pending_pre", 32'(pending), QEN ? 32'd2 : 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("mr_out_async", 32'(out), 32'd0);
        chk("mr_pending", 32'(pending), 32'd0);
        model_reset();
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        rises = 0;
        idle(15);
        chk("mr_no_pulse", 32'(rises), 32'd0);

        // Random traffic with lengths changing mid-pulse.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                high_len = CW'($urandom_range(0, 4));
                low_len  = CW'($urandom_range(0, 4));
            end
            step($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 60 : 15),
                 $urandom_range(0, 15) == 0);
        end
        idle(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
